piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in serial-out transmitter: the send side feeding the team's serial shift-register chain. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a qualifying valid strobe. It supports gap-free back-to-back words. It sits between a parallel producer and any serial consumer, such as the SISO register chain or a SIPO receiver.

## Interface
- WIDTH, 8: data word width, ≥1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- din  in  WIDTH  parallel word, sampled on the accepting edge only
- load_valid  in  1  producer offers din
- load_ready  out  1  transmitter can accept a word this cycle
- so  out  1  serial data
- so_valid  out  1  so carries a frame bit this cycle
- busy  out  1  a frame is in flight
- done  out  1  one-cycle pulse after the final frame bit

## Operation
- **States:** IDLE, SHIFT, PARITY. PARITY exists only with PARITY_EN.
- **Accept:** at a rising edge with load_valid && load_ready.
  - Capture din into the shift register.
  - Compute even parity as ^din.
  - Clear the bit counter and enter SHIFT.
- **SHIFT:** so = shreg[WIDTH-1] and so_valid = 1.
  - Each edge shifts left by one, zero-filled, and increments the counter.
  - Last bit is cnt == WIDTH-1.
- **After the last SHIFT bit:**
  - With PARITY_EN: enter PARITY. There, so = stored parity, so_valid = 1, and the state lasts 1 cycle.
  - Without PARITY_EN: the last SHIFT bit ends the frame.
- **Final bit cycle:** the last SHIFT bit, or the PARITY cycle when PARITY_EN is defined.
- **End of frame:**
  - If an accept occurs in the final bit cycle, re-enter SHIFT with the new word. There is no idle gap.
  - Otherwise go to IDLE.
- **load_ready** = (state == IDLE) || final bit cycle. It is combinational from state/cnt only and never depends on load_valid.
- **busy** = (state != IDLE).
- **IDLE outputs:** so = 0, so_valid = 0.
- load_valid while load_ready = 0 is ignored; din is not sampled.
- Counter width is max(1, $clog2(WIDTH)). For WIDTH = 1, every SHIFT cycle is the last bit.

## Timing
- **Reset values:**
  - Exact output values while rst = 0: so = 0, so_valid = 0, busy = 0, done = 0, load_ready = 1, state = IDLE.
  - Reset mid-frame aborts immediately. No done pulse is produced and the remaining bits are lost.
- **Latency:** a word accepted at edge N drives its MSB on so in the cycle after edge N.
- **Frame length:** WIDTH cycles, or WIDTH+1 cycles with PARITY_EN.
- **done** is registered. It is high for exactly the one cycle after the final bit cycle.
  - In back-to-back operation it coincides with the first bit of the next word.
- **Throughput:** one word per WIDTH (or WIDTH+1) cycles when load_valid is held high.

## Configuration
- PARITY_EN defined:
  - One even-parity bit is appended after the LSB.
  - The parity bit is marked with so_valid = 1.
  - The PARITY state and the parity register are present.
- PARITY_EN undefined:
  - The frame is the WIDTH data bits only.
  - No parity logic is synthesized.

## Structure
- **Shared package siso_pkg:**
  - state enum {IDLE, SHIFT, PARITY}
  - default width constant SISO_WIDTH = 8
- **Sub-module piso_bit_cnt:** a natural split.
  - Function: a clearable up-counter.
  - Ports: clk, rst, clr, en, cnt, last, where last = (cnt == WIDTH-1).
- The FSM and shift register stay in piso_tx.

## Test plan
- Reset held for 5 cycles, then released with no load → so = 0, so_valid = 0, busy = 0, load_ready = 1 throughout.
- Single load of din = 8'hA5 → so = 1,0,1,0,0,1,0,1 over 8 cycles with so_valid = 1. Then done for 1 cycle and busy = 0.
  - With PARITY_EN: a 9th bit = 0.
- PARITY_EN with din = 8'h07 → 8 data bits 0,0,0,0,0,1,1,1, then parity bit 1.
- load_valid held high with 8'hA5 then 8'h3C → 16 contiguous so_valid cycles (18 with PARITY_EN).
  - load_ready is high only in each final bit cycle.
  - done pulses coincide with the first bit of each following word.
- Second load_valid with 8'hFF asserted mid-frame at bit 3 and dropped before the final bit → ignored. The first word completes intact and the state returns to IDLE.
- rst pulled low at bit 4 of 8'hA5 → so, so_valid and busy go to 0 immediately. No done pulse follows. The next load after release transmits normally.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared types and constants for the serial shift-register chain blocks.
// Holds the frame state encoding and the counter-width helper used by piso_tx.
package siso_pkg;

  localparam int SISO_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  // Bit counter width: max(1, $clog2(w)), so a 1-bit word still gets a counter.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Clearable up-counter that tracks the data-bit index within a piso_tx frame.
// last flags the final data bit (cnt == WIDTH-1).
module piso_bit_cnt
  import siso_pkg::*;
#(
  parameter int WIDTH = SISO_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  output logic [cnt_width(WIDTH)-1:0] cnt,
  output logic                        last
);

  localparam int CW = cnt_width(WIDTH);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, MSB-first shift-out
// with so_valid strobe and gap-free back-to-back frames. Define PARITY_EN to append an even-parity bit.
module piso_tx
  import siso_pkg::*;
#(
  parameter int WIDTH = SISO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             final_bit;
`ifdef PARITY_EN
  logic             parity;
`endif

  piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == SHIFT),
    .cnt  (cnt),
    .last (last)
  );

  // The final bit cycle is the only point inside a frame where a new word may be taken.
`ifdef PARITY_EN
  assign final_bit = (state == PARITY);
`else
  assign final_bit = (state == SHIFT) && last;
`endif

  assign load_ready = (state == IDLE) || final_bit;
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    so        = 1'b0;
    so_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        so       = shreg[WIDTH-1];
        so_valid = 1'b1;
        if (last) begin
`ifdef PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        so        = parity;
        so_valid  = 1'b1;
        state_nxt = accept ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= final_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= din;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^din;
    end
  end
`endif

  // The counter is cleared on every accept, so it can never run past the last bit while shifting.
  cnt_in_range: assert property (@(posedge clk) disable iff (!rst)
    (state == SHIFT) |-> (cnt <= CW'(WIDTH - 1)));

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-of-frame-bits reference model.
module tb_piso_tx;
  import siso_pkg::*;

  localparam int WIDTH = SISO_WIDTH;
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  // Reference model: bits still to be sent in the current frame, plus the pending done pulse.
  bit mq[$];
  bit mdone = 1'b0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .so         (so),
    .so_valid   (so_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) mq.push_back(d[i]);
`ifdef PARITY_EN
    mq.push_back(^d);
`endif
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, advance the model at the rising edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d);
    bit acc;
    bit fin;
    load_valid = v;
    din        = d;
    #1;
    check("so_valid",   so_valid,   mq.size() > 0);
    check("so",         so,         (mq.size() > 0) ? mq[0] : 1'b0);
    check("busy",       busy,       mq.size() > 0);
    check("load_ready", load_ready, mq.size() <= 1);
    check("done",       done,       mdone);
    acc = v && (mq.size() <= 1);
    fin = (mq.size() == 1);
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    if (acc) push_frame(d);
    mdone = fin;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  // Assert reset now (mid-cycle), check the immediate abort, hold for n cycles, then release.
  task automatic do_reset(input int n);
    rst        = 1'b0;
    load_valid = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      check("rst_so",         so,         1'b0);
      check("rst_so_valid",   so_valid,   1'b0);
      check("rst_busy",       busy,       1'b0);
      check("rst_done",       done,       1'b0);
      check("rst_load_ready", load_ready, 1'b1);
      @(negedge clk);
      #1;
    end
    mq.delete();
    mdone = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [WIDTH-1:0] cap;

  initial begin
    @(negedge clk);
    do_reset(5);
    idle(4);

    // Single word, captured serially and compared as a word.
    step(1'b1, 8'hA5);
    cap = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cap = {cap[WIDTH-2:0], so};
      step(1'b0, '0);
    end
    check("a5_word", cap, 8'hA5);
    idle(FRAME - WIDTH + 3);

    // Word with odd population, parity bit 1 when enabled.
    step(1'b1, 8'h07);
    idle(FRAME + 2);

    // load_valid held high: A5 then 3C back to back, taken in A5's final bit cycle.
    step(1'b1, 8'hA5);
    for (int i = 0; i < FRAME; i++) step(1'b1, 8'h3C);
    idle(FRAME + 2);

    // Offer FF mid-frame (bits 3..5); must be ignored.
    step(1'b1, 8'hA5);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF);
    idle(FRAME + 2);

    // Reset at bit 4 of A5, then a normal frame afterwards.
    step(1'b1, 8'hA5);
    idle(4);
    do_reset(2);
    idle(2);
    step(1'b1, 8'h5A);
    idle(FRAME + 2);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 3) != 0, WIDTH'($urandom));
      end
    end
    idle(FRAME + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
